// File: rtl/if_stage_if.sv
// IF-stage bus: redirect/stall controls in, fetch address out, IF/ID register out.
interface if_stage_if;
  logic        stall;
  logic        npc_sel;
  logic [31:0] npc;
  logic        id_is_branch;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_bd;
  logic        id_valid;
  logic        id_exc;
  logic [4:0]  id_exccode;

  modport slave (
    input  stall, npc_sel, npc, id_is_branch, exc_req, eret_req, epc, instr,
    output pc, id_instr, id_pc, id_pc8, id_bd, id_valid, id_exc, id_exccode
  );

  modport master (
    output stall, npc_sel, npc, id_is_branch, exc_req, eret_req, epc, instr,
    input  pc, id_instr, id_pc, id_pc8, id_bd, id_valid, id_exc, id_exccode
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Optional FETCH_ADDR_CHECK_EN builds the alignment/text-range AdEL check.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_4FFC
) (
  input logic      clk,
  input logic      reset,
  if_stage_if.slave bus
);

  logic [31:0] pc_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic        id_bd_q;
  logic        id_valid_q;
  logic        fetch_ok;

`ifdef FETCH_ADDR_CHECK_EN
  logic id_exc_q;

  assign fetch_ok = (pc_q[1:0] == 2'b00) && (pc_q >= TEXT_LO) && (pc_q <= TEXT_HI);

  always_ff @(posedge clk) begin
    if (!reset || bus.exc_req || bus.eret_req) begin
      id_exc_q <= 1'b0;
    end else if (!bus.stall) begin
      id_exc_q <= !fetch_ok;
    end
  end

  assign bus.id_exc     = id_exc_q;
  assign bus.id_exccode = id_exc_q ? 5'd4 : 5'd0;
`else
  logic unused_bounds;

  assign unused_bounds  = ^{TEXT_LO, TEXT_HI};
  assign fetch_ok       = 1'b1;
  assign bus.id_exc     = 1'b0;
  assign bus.id_exccode = '0;
`endif

  // Redirects flush IF/ID even when stalled; a stalled npc_sel is dropped, ID re-presents it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_bd_q    <= 1'b0;
      id_valid_q <= 1'b0;
    end else if (bus.exc_req || bus.eret_req) begin
      pc_q       <= bus.exc_req ? EXC_VECTOR : bus.epc;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_bd_q    <= 1'b0;
      id_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q       <= bus.npc_sel ? bus.npc : pc_q + 32'd4;
      id_instr_q <= fetch_ok ? bus.instr : '0;
      id_pc_q    <= pc_q;
      id_bd_q    <= bus.id_is_branch;
      id_valid_q <= 1'b1;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.id_instr = id_instr_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_pc8   = id_pc_q + 32'd8;
  assign bus.id_bd    = id_bd_q;
  assign bus.id_valid = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: each driven cycle pushes the expected post-edge state.
module tb_if_stage;

  logic clk;
  logic reset;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC  (32'h0000_3000),
    .EXC_VECTOR(32'h0000_4180),
    .TEXT_LO   (32'h0000_3000),
    .TEXT_HI   (32'h0000_4FFC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F19;
  endfunction

  assign bus.instr = imword(bus.pc);

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  function automatic logic legal(input logic [31:0] a);
    if (!CHK) return 1'b1;
    return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a <= 32'h4FFC);
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] idpc;
    logic        bd;
    logic        valid;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic st, input logic ns, input logic [31:0] nv,
                      input logic br, input logic ex, input logic er, input logic [31:0] ep);
    exp_t e;
    reset            = rst_n;
    bus.stall        = st;
    bus.npc_sel      = ns;
    bus.npc          = nv;
    bus.id_is_branch = br;
    bus.exc_req      = ex;
    bus.eret_req     = er;
    bus.epc          = ep;
    if (!rst_n) begin
      e = '{32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    end else if (ex || er) begin
      e = '{(ex ? 32'h4180 : ep), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    end else if (st) begin
      e = m;
    end else begin
      e.pc    = ns ? nv : m.pc + 32'd4;
      e.idpc  = m.pc;
      e.bd    = br;
      e.valid = 1'b1;
      e.exc   = !legal(m.pc);
      e.instr = legal(m.pc) ? imword(m.pc) : 32'h0;
    end
    m = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("pc",       bus.pc,         e.pc);
      check("id_instr", bus.id_instr,   e.instr);
      check("id_pc",    bus.id_pc,      e.idpc);
      check("id_pc8",   bus.id_pc8,     e.idpc + 32'd8);
      check("id_bd",    {31'b0, bus.id_bd},    {31'b0, e.bd});
      check("id_valid", {31'b0, bus.id_valid}, {31'b0, e.valid});
      check("id_exc",   {31'b0, bus.id_exc},   {31'b0, e.exc});
      check("id_exccode", {27'b0, bus.id_exccode}, e.exc ? 32'd4 : 32'd0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic jump(input logic [31:0] t);
    step(1, 0, 1, t, 0, 0, 0, 32'h0);
  endtask

  initial begin
    m = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    reset = 1'b0;

    step(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    check("reset_pc", bus.pc, 32'h3000);
    check("reset_valid", {31'b0, bus.id_valid}, 32'd0);

    run(2);
    check("free_pc", bus.pc, 32'h3008);
    check("free_idpc", bus.id_pc, 32'h3004);

    // Branch resolved while 0x3008 is fetched; next fetch is marked as the delay slot.
    jump(32'h3100);
    check("br_pc", bus.pc, 32'h3100);
    check("br_idpc", bus.id_pc, 32'h3008);
    step(1, 0, 0, 32'h0, 1, 0, 0, 32'h0);
    check("ds_bd", {31'b0, bus.id_bd}, 32'd1);
    check("ds_pc8", bus.id_pc8, 32'h3108);

    step(1, 1, 1, 32'h3200, 0, 0, 0, 32'h0);
    step(1, 1, 1, 32'h3200, 0, 0, 0, 32'h0);
    check("stall_pc", bus.pc, 32'h3104);
    jump(32'h3200);
    check("release_pc", bus.pc, 32'h3200);

    jump(32'h3020);
    step(1, 1, 0, 32'h0, 0, 1, 0, 32'h0);
    check("exc_pc", bus.pc, 32'h4180);
    check("exc_instr", bus.id_instr, 32'h0);
    step(1, 0, 0, 32'h0, 0, 0, 1, 32'h3024);
    check("eret_pc", bus.pc, 32'h3024);
    run(1);
    check("eret_fetch_idpc", bus.id_pc, 32'h3024);

    jump(32'h3002);
    run(1);
    check("misalign_exc", {31'b0, bus.id_exc}, {31'b0, CHK});
    jump(32'h5000);
    run(1);
    check("range_hi_exc", {31'b0, bus.id_exc}, {31'b0, CHK});
    jump(32'h4FFC);
    run(2);
    jump(32'h2FFC);
    run(1);
    check("range_lo_exc", {31'b0, bus.id_exc}, {31'b0, CHK});

    jump(32'hFFFF_FFFC);
    run(1);
    check("wrap_pc", bus.pc, 32'h0);

    step(1, 1, 0, 32'h0, 0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h3300, 1, 1, 0, 32'h0);
    check("rst_mid_pc", bus.pc, 32'h3000);
    check("rst_mid_instr", bus.id_instr, 32'h0);

    for (int i = 0; i < 80; i++) begin
      int unsigned r;
      logic [31:0] nv;
      r  = $urandom_range(0, 99);
      nv = 32'h2FF0 + (32'($urandom_range(0, 32'h2020)) & ~32'h3);
      if ($urandom_range(0, 9) == 0) nv[1:0] = 2'($urandom_range(1, 3));
      step(!(r < 3), $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, nv,
           $urandom_range(0, 1) == 1, (r >= 3 && r < 8), (r >= 8 && r < 13), nv ^ 32'h4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
